mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter with per-cycle watchdog and registered outputs.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; default is fixed priority.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic       sysClk,
  input  logic       sysReset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       memStart,
  input  logic       memDone,
  input  logic       memBerr,
  output logic [1:0] ack,
  output logic [1:0] berr,
  output logic       owner
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ACTIVE,
    RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_d;
  logic [1:0]       gnt_d;
  logic [1:0]       ack_d;
  logic [1:0]       berr_d;
  logic             start_d;
  logic             owner_d;
  logic             win;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  function automatic logic [1:0] oh(input logic i);
    return i ? 2'b10 : 2'b01;
  endfunction

`ifdef MEM_ARBITER_RR_EN
  logic last;
  logic last_d;

  // on contention the master not granted last wins
  assign win = (req == 2'b11) ? ~last : req[1];
`else
  assign win = ~req[0];
`endif

  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    start_d = 1'b0;
    ack_d   = 2'b00;
    berr_d  = 2'b00;
    owner_d = owner;
    cnt_d   = cnt;
`ifdef MEM_ARBITER_RR_EN
    last_d  = last;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_d   = oh(win);
          owner_d = win;
          state_d = GRANT;
`ifdef MEM_ARBITER_RR_EN
          last_d  = win;
`endif
        end else begin
          gnt_d = 2'b00;
        end
      end
      GRANT: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!req[owner]) begin
          gnt_d   = 2'b00;
          state_d = IDLE;
        end else if (memBerr || memDone || cnt == LIMIT) begin
          // bus error beats normal termination; timeout only without memDone
          if (memBerr || !memDone) begin
            berr_d = oh(owner);
          end else begin
            ack_d = oh(owner);
          end
          state_d = RELEASE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (!req[owner]) begin
          gnt_d   = 2'b00;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state    <= IDLE;
      gnt      <= 2'b00;
      memStart <= 1'b0;
      ack      <= 2'b00;
      berr     <= 2'b00;
      owner    <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      memStart <= start_d;
      ack      <= ack_d;
      berr     <= berr_d;
      owner    <= owner_d;
      cnt      <= cnt_d;
    end
  end

`ifdef MEM_ARBITER_RR_EN
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      last <= 1'b1;
    end else begin
      last <= last_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-cycle expected outputs queued by
// the stimulus process and checked by an independent monitor.
module tb_mem_arbiter;

  logic       sysClk = 1'b0;
  logic       sysReset;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       memStart;
  logic       memDone;
  logic       memBerr;
  logic [1:0] ack;
  logic [1:0] berr;
  logic       owner;

  logic [7:0] expq[$];
  logic [7:0] tagq[$];
  int         nvec = 0;
  int         nbad = 0;
  int         step = 0;

`ifdef MEM_ARBITER_RR_EN
  localparam logic WO = 1'b1;
`else
  localparam logic WO = 1'b0;
`endif
  localparam logic [1:0] GW = WO ? 2'b10 : 2'b01;

  mem_arbiter #(
    .TIMEOUT_CYCLES(64),
    .CNT_W(8)
  ) dut (
    .sysClk(sysClk),
    .sysReset(sysReset),
    .req(req),
    .gnt(gnt),
    .memStart(memStart),
    .memDone(memDone),
    .memBerr(memBerr),
    .ack(ack),
    .berr(berr),
    .owner(owner)
  );

  always #5 sysClk = ~sysClk;

  // one cycle: queue the outputs expected in this cycle, then apply inputs
  task automatic cyc(
    input logic       rs,
    input logic [1:0] r,
    input logic       d,
    input logic       b,
    input logic [1:0] g,
    input logic       ms,
    input logic [1:0] a,
    input logic [1:0] be,
    input logic       o
  );
    @(posedge sysClk);
    #1;
    step++;
    expq.push_back({g, ms, a, be, o});
    tagq.push_back(8'(step));
    sysReset = rs;
    req      = r;
    memDone  = d;
    memBerr  = b;
  endtask

  always @(negedge sysClk) begin
    if (expq.size() > 0) begin
      logic [7:0] e;
      logic [7:0] t;
      logic [7:0] got;
      e   = expq.pop_front();
      t   = tagq.pop_front();
      got = {gnt, memStart, ack, berr, owner};
      nvec++;
      if (got !== e) begin
        nbad++;
        $display("FAIL cycle%0d {gnt,memStart,ack,berr,owner}: got %b, want %b",
                 t, got, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global time limit expired");
    $fatal(1);
  end

  initial begin
    sysReset = 1'b1;
    req      = 2'b00;
    memDone  = 1'b0;
    memBerr  = 1'b0;

    // reset state
    cyc(1, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    cyc(0, 2'b11, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    // contention: CPU first in both builds
    cyc(0, 2'b11, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0);
    cyc(0, 2'b11, 1, 0, 2'b01, 1, 2'b00, 2'b00, 0);
    cyc(0, 2'b10, 0, 0, 2'b01, 0, 2'b01, 2'b00, 0);
    cyc(0, 2'b11, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    // second contention: CPU (fixed) or DMA (round-robin)
    cyc(0, 2'b11, 0, 0, GW,    0, 2'b00, 2'b00, WO);
    cyc(0, 2'b11, 1, 0, GW,    1, 2'b00, 2'b00, WO);
    cyc(0, 2'b00, 0, 0, GW,    0, GW,    2'b00, WO);
    cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, WO);
    // single CPU access, memDone on third ACTIVE cycle
    cyc(0, 2'b01, 0, 0, 2'b00, 0, 2'b00, 2'b00, WO);
    cyc(0, 2'b01, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0);
    cyc(0, 2'b01, 0, 0, 2'b01, 1, 2'b00, 2'b00, 0);
    cyc(0, 2'b01, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0);
    cyc(0, 2'b01, 1, 0, 2'b01, 0, 2'b00, 2'b00, 0);
    cyc(0, 2'b00, 0, 0, 2'b01, 0, 2'b01, 2'b00, 0);
    cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    // DMA watchdog: 64 silent ACTIVE cycles
    cyc(0, 2'b10, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    cyc(0, 2'b10, 0, 0, 2'b10, 0, 2'b00, 2'b00, 1);
    cyc(0, 2'b10, 0, 0, 2'b10, 1, 2'b00, 2'b00, 1);
    for (int k = 2; k <= 64; k++) begin
      cyc(0, 2'b10, 0, 0, 2'b10, 0, 2'b00, 2'b00, 1);
    end
    cyc(0, 2'b00, 0, 0, 2'b10, 0, 2'b00, 2'b10, 1);
    cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1);
    // memDone and memBerr together
    cyc(0, 2'b01, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1);
    cyc(0, 2'b01, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0);
    cyc(0, 2'b01, 1, 1, 2'b01, 1, 2'b00, 2'b00, 0);
    cyc(0, 2'b00, 0, 0, 2'b01, 0, 2'b00, 2'b01, 0);
    cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    // abort by DMA, late terminations ignored
    cyc(0, 2'b10, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    cyc(0, 2'b10, 0, 0, 2'b10, 0, 2'b00, 2'b00, 1);
    cyc(0, 2'b10, 0, 0, 2'b10, 1, 2'b00, 2'b00, 1);
    cyc(0, 2'b00, 0, 0, 2'b10, 0, 2'b00, 2'b00, 1);
    cyc(0, 2'b00, 1, 0, 2'b00, 0, 2'b00, 2'b00, 1);
    cyc(0, 2'b00, 0, 1, 2'b00, 0, 2'b00, 2'b00, 1);
    cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1);
    // reset in ACTIVE, then a normal access
    cyc(0, 2'b01, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1);
    cyc(0, 2'b01, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0);
    cyc(0, 2'b01, 0, 0, 2'b01, 1, 2'b00, 2'b00, 0);
    cyc(1, 2'b01, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0);
    cyc(0, 2'b01, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    cyc(0, 2'b01, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0);
    cyc(0, 2'b01, 1, 0, 2'b01, 1, 2'b00, 2'b00, 0);
    cyc(0, 2'b00, 0, 0, 2'b01, 0, 2'b01, 2'b00, 0);
    cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);

    for (int w = 0; w < 4 && expq.size() > 0; w++) begin
      @(posedge sysClk);
    end
    if (expq.size() > 0) begin
      nbad++;
      $display("FAIL drain: got %0d pending, want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
